instr_prefetch: RTL and testbench

- Instruction prefetch stage; sits directly downstream of `instr_rom`, which it reaches through the instruction-side naive_bus.
- Acts as a naive_bus master. Issues sequential word reads and absorbs the slave's one-cycle read latency.
- Buffers {pc, instr} pairs in a small FIFO and hands them to decode over a valid/ready handshake.
- Accepts a redirect (branch/jump/trap) that flushes all buffered and in-flight fetches.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/naive_bus.sv | 25 ++
 rtl/fetch_fifo.sv | 69 ++++++
 rtl/instr_prefetch.sv | 110 +++++++++++
 tb/tb_instr_prefetch.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction prefetch slice.
// Latency: n/a (types only).
// Backpressure: n/a.
package fetch_pkg;

  // One buffered fetch result: the word and the address it came from.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam int          INSTR_BYTES = 4;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

  // Instruction fetches are always word aligned; low address bits are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/naive_bus.sv
// Simple split read/write bus between a master and a single slave.
// Latency: read data returns one cycle after the rd_req/rd_gnt edge.
// Backpressure: slave stalls a request by holding rd_gnt/wr_gnt low.
interface naive_bus;
  logic        rd_req;
  logic        rd_gnt;
  logic [3:0]  rd_be;
  logic [31:0] rd_addr;
  logic [31:0] rd_data;
  logic        wr_req;
  logic        wr_gnt;
  logic [3:0]  wr_be;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  modport master (
    output rd_req, rd_be, rd_addr, wr_req, wr_be, wr_addr, wr_data,
    input  rd_gnt, rd_data, wr_gnt
  );

  modport slave (
    input  rd_req, rd_be, rd_addr, wr_req, wr_be, wr_addr, wr_data,
    output rd_gnt, rd_data, wr_gnt
  );
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of {pc, instr} entries with a flush that empties it in one edge.
// Latency: a pushed entry is visible at head the cycle after the push edge.
// Backpressure: push ignored when full, pop ignored when empty; flush overrides both.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  fetch_entry_t               wdata,
  input  logic                       pop,
  input  logic                       flush,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output fetch_entry_t               head
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   PTR_ONE = (AW+1)'(1);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  fetch_entry_t mem_q [DEPTH];
  logic         do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count   = wr_ptr_q - rd_ptr_q;
  assign do_push = push && !flush && !full;
  assign do_pop  = pop  && !flush && !empty;

  // Head reads zero when nothing is buffered so stale storage never leaks out.
  assign head = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  // Next pointer values: flush wins, otherwise push and pop advance independently.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage; contents are don't-care until written because head is gated by empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/instr_prefetch.sv
// Sequential instruction prefetcher: issues word reads on naive_bus and buffers {pc, instr}.
// Latency: first out_valid two cycles after reset release with rd_gnt=1; one word per cycle after.
// Backpressure: stops requesting when buffered plus in-flight entries reach FIFO_DEPTH.
module instr_prefetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  naive_bus.master         bus,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_instr
);

  localparam int          CW        = $clog2(FIFO_DEPTH);
  localparam logic [CW:0] DEPTH_OCC = (CW+1)'(FIFO_DEPTH);

  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  issued_pc_q, issued_pc_d;
  logic         inflight_q, inflight_d;
  logic         drop_q, drop_d;

  logic         rd_req;
  logic         grant;
  logic         push, pop;
  logic         fifo_full, fifo_empty;
  logic [CW:0]  fifo_count;
  logic [CW:0]  occupancy;
  fetch_entry_t push_entry;
  fetch_entry_t head_entry;
  logic         unused_wr_gnt;

  // Count the in-flight word as occupied so a returning response always has a slot.
  assign occupancy = fifo_count + {{CW{1'b0}}, inflight_q};
  assign rd_req    = rst_n && !redirect_valid && (occupancy < DEPTH_OCC);
  assign grant     = rd_req && bus.rd_gnt;

  assign bus.rd_req  = rd_req;
  assign bus.rd_addr = fetch_pc_q;
  assign bus.rd_be   = 4'hF;
  assign bus.wr_req  = 1'b0;
  assign bus.wr_be   = 4'h0;
  assign bus.wr_addr = 32'h0;
  assign bus.wr_data = 32'h0;
  assign unused_wr_gnt = bus.wr_gnt;

  // A redirect flushes the FIFO itself, so it also suppresses this cycle's push and pop.
  assign push       = inflight_q && !drop_q && !redirect_valid;
  assign pop        = out_valid && out_ready && !redirect_valid;
  assign push_entry = '{pc: issued_pc_q, instr: bus.rd_data};

  assign out_valid = !fifo_empty;
  assign out_pc    = head_entry.pc;
  assign out_instr = head_entry.instr;

  // Request/response bookkeeping: advance on grant, restart on redirect.
  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    issued_pc_d = issued_pc_q;
    inflight_d  = grant;
    drop_d      = 1'b0;
    if (redirect_valid) begin
      fetch_pc_d = word_align(redirect_pc);
      drop_d     = inflight_q;
    end else if (grant) begin
      fetch_pc_d  = fetch_pc_q + 32'(INSTR_BYTES);
      issued_pc_d = fetch_pc_q;
    end
  end

  // Control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q  <= RESET_PC;
      issued_pc_q <= 32'h0;
      inflight_q  <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      issued_pc_q <= issued_pc_d;
      inflight_q  <= inflight_d;
      drop_q      <= drop_d;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (push_entry),
    .pop   (pop),
    .flush (redirect_valid),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .head  (head_entry)
  );

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_instr_prefetch.sv
module tb_instr_prefetch;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        gnt, rdy, redir;
  logic [31:0] rpc;
  logic        out_valid;
  logic [31:0] out_pc, out_instr;

  int total = 0;
  int bad   = 0;

  naive_bus bus ();

  always #5 clk = ~clk;

  instr_prefetch #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .redirect_valid (redir),
    .redirect_pc    (rpc),
    .out_valid      (out_valid),
    .out_ready      (rdy),
    .out_pc         (out_pc),
    .out_instr      (out_instr)
  );

  // Instruction memory contents: known words at the directed addresses, a hash elsewhere.
  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0000_62b3;
      32'h0000_0004: return 32'h0003_02b7;
      32'h0000_0008: return 32'h0680_6313;
      32'h0000_0010: return 32'h0650_6313;
      32'h0000_004C: return 32'hfbdf_f06f;
      32'h0000_0050: return 32'h0000_0000;
      default:       return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endcase
  endfunction

  // Slave side: one-cycle read latency.
  assign bus.rd_gnt = gnt;
  assign bus.wr_gnt = 1'b0;
  always @(posedge clk) begin
    if (bus.rd_req && bus.rd_gnt) bus.rd_data <= rom(bus.rd_addr);
  end

  // Reference model: next fetch address, at most one outstanding read, and a queue of words.
  logic [31:0] m_pc, m_ipc;
  bit          m_inf;
  logic [63:0] mq[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_pc  = 32'h0;
    m_ipc = 32'h0;
    m_inf = 0;
    mq.delete();
  endfunction

  function automatic bit model_req();
    return !redir && (mq.size() + int'(m_inf) < DEPTH);
  endfunction

  // Apply inputs for one cycle and compare every visible output against the model.
  task automatic drive(input bit g, input bit r, input bit rv, input logic [31:0] rp);
    logic [63:0] h;
    @(negedge clk);
    rst_n = 1'b1;
    gnt = g; rdy = r; redir = rv; rpc = rp;
    #1;
    h = (mq.size() != 0) ? mq[0] : 64'h0;
    check("rd_req", bus.rd_req, model_req());
    check("rd_addr", bus.rd_addr, m_pc);
    check("rd_be", bus.rd_be, 4'hF);
    check("out_valid", out_valid, mq.size() != 0);
    check("out_pc", out_pc, h[63:32]);
    check("out_instr", out_instr, h[31:0]);
    check("wr_side", (bus.wr_req || bus.wr_be != 0 || bus.wr_addr != 0 || bus.wr_data != 0), 1'b0);
  endtask

  // Advance the model across the clock edge using the inputs held for this cycle.
  task automatic tick();
    bit req;
    @(posedge clk);
    req = model_req();
    if (redir) begin
      mq.delete();
      m_inf = 0;
      m_pc  = {rpc[31:2], 2'b00};
    end else begin
      if (mq.size() != 0 && rdy) void'(mq.pop_front());
      if (m_inf) mq.push_back({m_ipc, rom(m_ipc)});
      m_inf = 0;
      if (req && gnt) begin
        m_ipc = m_pc;
        m_inf = 1;
        m_pc  = m_pc + 32'd4;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_rd_req", bus.rd_req, 1'b0);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_out_instr", out_instr, 32'h0);
    model_reset();
    @(posedge clk);
  endtask

  logic [31:0] first_words [3];
  int          ng;
  bit          found;

  initial begin
    first_words[0] = 32'h0000_62b3;
    first_words[1] = 32'h0003_02b7;
    first_words[2] = 32'h0680_6313;
    rst_n = 1'b0; gnt = 1'b0; rdy = 1'b0; redir = 1'b0; rpc = 32'h0;
    model_reset();
    #3;
    check("init_rd_req", bus.rd_req, 1'b0);
    check("init_out_valid", out_valid, 1'b0);
    check("init_out_pc", out_pc, 32'h0);
    check("init_out_instr", out_instr, 32'h0);

    // Startup latency and first three words.
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 0, 0);
      check("startup_no_vld", out_valid, 1'b0);
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, 0, 0);
      check("startup_vld", out_valid, 1'b1);
      check("startup_pc", out_pc, 32'(k * 4));
      check("startup_instr", out_instr, first_words[k]);
      tick();
    end

    // Decode stalled: only FIFO_DEPTH grants, then in-order delivery.
    do_reset();
    ng = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 0, 0);
      if (bus.rd_req) ng++;
      tick();
    end
    check("bp_grants", ng, DEPTH);
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 0, 0);
      check("bp_pc", out_pc, 32'(i * 4));
      tick();
    end

    // Bus stall at 0x10.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      if (m_pc == 32'h10) break;
      drive(1, 1, 0, 0);
      tick();
    end
    check("stall_reach", m_pc, 32'h10);
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 0, 0);
      check("stall_req", bus.rd_req, 1'b1);
      check("stall_addr", bus.rd_addr, 32'h10);
      tick();
    end
    found = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1, 1, 0, 0);
      if (out_valid && out_pc == 32'h10) begin
        found = 1;
        check("stall_instr", out_instr, 32'h0650_6313);
      end
      tick();
      if (found) break;
    end
    check("stall_found", found, 1'b1);

    // Redirect while 0x20 is in flight.
    for (int i = 0; i < 30; i++) begin
      if (m_inf && m_ipc == 32'h20) break;
      drive(1, 1, 0, 0);
      tick();
    end
    check("redir_reach", m_inf && m_ipc == 32'h20, 1'b1);
    drive(1, 1, 1, 32'h4E);
    check("redir_req_low", bus.rd_req, 1'b0);
    tick();
    drive(1, 1, 0, 0);
    check("redir_addr", bus.rd_addr, 32'h4C);
    check("redir_empty", out_valid, 1'b0);
    tick();
    for (int i = 0; i < 10; i++) begin
      drive(1, 1, 0, 0);
      if (out_valid) break;
      tick();
    end
    check("redir_pc0", out_pc, 32'h4C);
    check("redir_instr0", out_instr, 32'hfbdf_f06f);
    tick();
    drive(1, 1, 0, 0);
    check("redir_pc1", out_pc, 32'h50);
    check("redir_instr1", out_instr, 32'h0);
    tick();

    // Reset pulse mid-stream.
    do_reset();
    for (int i = 0; i < 30; i++) begin
      if (m_pc == 32'h30) break;
      drive(1, 1, 0, 0);
      tick();
    end
    check("midrst_reach", m_pc, 32'h30);
    do_reset();
    drive(1, 1, 0, 0);
    check("midrst_addr", bus.rd_addr, 32'h0);
    check("midrst_empty", out_valid, 1'b0);
    tick();

    // Address wrap at the top of memory.
    drive(1, 1, 1, 32'hFFFF_FFFF);
    tick();
    drive(1, 1, 0, 0);
    check("wrap_addr0", bus.rd_addr, 32'hFFFF_FFFC);
    tick();
    drive(1, 1, 0, 0);
    check("wrap_addr1", bus.rd_addr, 32'h0);
    tick();
    drive(1, 1, 0, 0);
    check("wrap_out_pc", out_pc, 32'hFFFF_FFFC);
    tick();

    // Random traffic: grant stalls, decode stalls, redirects and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(499) == 0) begin
        do_reset();
      end else begin
        drive($urandom_range(99) < 70, $urandom_range(99) < 60,
              $urandom_range(29) == 0, $urandom);
        tick();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
